// File: rtl/imem_pkg.sv
// Shared types and constants for the clocked instruction memory.
package imem_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  // Word returned on a faulting fetch.
  localparam int unsigned NOP_WORD = 0;

  // Ceiling log2; elaboration-time use only.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W single-port-write / synchronous-read RAM, write-first, no reset.
module imem_ram
  import imem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int AW     = log2c(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and read register carry no reset so they map onto RAM macros;
  // anything observable after reset is masked by the control logic instead.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_sync.sv
// Clocked instruction memory: run-time loader plus one-cycle-latency fetch
// with req/ready, valid/ack handshake and misaligned/out-of-range fault reporting.
module imem_sync
  import imem_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int AW     = log2c(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              valid_o,
  output logic              fault_o,
  input  logic              ack_i,
  input  logic              ld_en_i,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              busy_o,
  output logic [AW:0]       ld_count_o
);

  localparam logic [ADDR_W-1:0] HI_MASK  = {ADDR_W{1'b1}} << (AW + 2);
  localparam logic [AW:0]       CNT_MAX  = (AW + 1)'(DEPTH);

  state_e            state_q;
  logic              valid_q;
  logic              fault_q;
  logic              rd_ok_q;   // held word came from the RAM, not a fault/reset
  logic [AW:0]       ld_count_q;

  logic              accept;
  logic              fault_d;
  logic [DATA_W-1:0] ram_rdata;

  assign ready_o = (state_q == ST_RUN) && !ld_en_i && (!valid_q || ack_i);
  assign busy_o  = (state_q == ST_LOAD);
  assign accept  = req_i && ready_o;
  assign fault_d = (|addr_i[1:0]) || (|(addr_i & HI_MASK));

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ld_en_i),
    .waddr_i (ld_addr_i),
    .wdata_i (ld_data_i),
    .re_i    (accept && !fault_d),
    .raddr_i (addr_i[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      ld_count_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ld_en_i) begin
            state_q    <= ST_LOAD;
            ld_count_q <= (AW + 1)'(1);
          end
        end
        ST_LOAD: begin
          if (!ld_en_i) begin
            state_q <= ST_RUN;
          end else if (ld_count_q != CNT_MAX) begin
            ld_count_q <= ld_count_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase

      if (accept) begin
        valid_q <= 1'b1;
        fault_q <= fault_d;
        rd_ok_q <= !fault_d;
      end else if (valid_q && ack_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o    = valid_q;
  assign fault_o    = fault_q;
  assign ld_count_o = ld_count_q;
  assign inst_o     = rd_ok_q ? ram_rdata : DATA_W'(NOP_WORD);

endmodule
